alu_seq_core: RTL
=================

Name: alu_seq_core

Overview:
- Parametrised successor to the 8-bit combinational ALU used in the TinyTapeout top.
- Adds a small register file, a valid/ready input handshake, registered results and flags, and a multi-cycle shift-add multiplier.
- Sits between the top-level pin mapping (ui_in, uio_in, uio_out, uo_out) and a future instruction sequencer.
- Each accepted operation reads two operands, computes, writes a destination register, and reports result plus flags.

Parameters:
- WIDTH, 8: datapath width in bits (>=4).
- NREGS, 4: register file depth (power of two, >=2); AW = clog2(NREGS).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  global enable; low freezes all state
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request this cycle
- opcode  in  4  operation select
- rd_addr  in  AW  destination register
- rs_addr  in  AW  operand A register
- rt_addr  in  AW  operand B register
- use_imm  in  1  1: B = imm, 0: B = regs[rt_addr]
- imm  in  WIDTH  immediate operand
- out_valid  out  1  one-cycle pulse: result/flags updated
- result  out  WIDTH  last completed result
- zero_flag  out  1  result == 0
- carry_flag  out  1  carry/borrow/overflow (per op)
- neg_flag  out  1  result[WIDTH-1]

Behaviour:
- Reset (async, rst_n=0):
  - All regs, result and flags are 0; out_valid=0; state=IDLE.
  - in_ready=1 once rst_n is high and ena=1.
  - Reset during MUL aborts it: no write, no out_valid.
- in_ready = ena & (state==IDLE). A request is accepted at an edge where in_valid & in_ready.
- ena=0: no state changes (regs, state, MUL counter, out_valid hold); in_ready=0.
- Opcodes (A = regs[rs_addr], B as per use_imm):
  - 0 ADD: A+B; carry = carry-out.
  - 1 SUB: A-B; carry = borrow (A<B).
  - 2 AND, 3 OR, 4 XOR: carry=0.
  - 5 SHL: A << (B mod WIDTH); carry = last bit shifted out, 0 if amount 0.
  - 6 SHR (logical): A >> (B mod WIDTH); carry as SHL.
  - 7 MUL: low WIDTH bits of A*B; carry = 1 if high half nonzero.
  - 8 LOAD: result=B; carry=0.
  - 9 ADC: A+B+carry_flag; carry = carry-out.
  - 10-15 NOP: no register write, no flag or result update, out_valid still pulses (result holds).
- Single-cycle ops (all except MUL):
  - At the accept edge: regs[rd_addr], result and flags are written.
  - out_valid=1 for the following cycle.
  - in_ready stays 1, so back-to-back issue is allowed.
  - The next op sees the updated register: no hazard.
- MUL (FSM IDLE -> MUL -> IDLE):
  - Accept edge latches A, B and rd_addr, clears the accumulator and counter, and enters MUL.
  - One shift-add iteration per enabled edge, WIDTH iterations total.
  - The WIDTH-th iteration edge writes regs[rd], result and flags, and returns to IDLE. out_valid=1 during the next cycle, in which in_ready is already 1.
  - in_ready=0 for exactly WIDTH cycles after acceptance.
- Flags: zero = (new result==0); neg = MSB of new result. Updated only on completing non-NOP ops.
- rd_addr == rs_addr or rt_addr is legal. Operands are read before the write.
- Widths: internal add/sub at WIDTH+1 bits; MUL accumulator 2*WIDTH bits.

Decomposition:
- Package alu_seq_pkg:
  - opcode localparams (OP_ADD..OP_ADC, OP_NOP range)
  - FSM state encodings (ST_IDLE, ST_MUL)
- Sub-module alu_seq_comb: purely combinational single-cycle op unit (A, B, carry_in, opcode -> result, carry). Reused later by the sequencer.
- Register file, FSM and multiplier stay in alu_seq_core.

Test Plan (WIDTH=8, NREGS=4):
- Reset, release with ena=1 -> all outputs 0, in_ready=1. LOAD imm 0 is not needed: regs read 0.
- LOAD r1,#0xF0 then next cycle ADD r2=r1+#0x20 -> second out_valid: result=0x10, carry=1, zero=0, neg=0; r2=0x10.
- SUB r3=r0-#0x01 -> result=0xFF, carry=1, neg=1. Then ADC r3=r3+#0x00 -> result=0x00, carry=1, zero=1.
- LOAD r1,#0x0F; MUL r2=r1*#0x11 -> in_ready low 8 cycles, out_valid 8 cycles after accept edge, result=0xFF, carry=0. MUL #0x80*#0x02 -> result=0x00, zero=1, carry=1.
- Start MUL, drop rst_n on 4th busy cycle -> out_valid never pulses, all regs 0, in_ready=1 after release.
- During MUL drop ena for 3 cycles -> completion delayed exactly 3 cycles, same result. Opcode 12 -> out_valid pulses, result/flags/regs unchanged.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes and FSM states shared by the sequential ALU core
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_MUL  = 4'd7;
  localparam logic [3:0] OP_LOAD = 4'd8;
  localparam logic [3:0] OP_ADC  = 4'd9;
  // Opcodes at or above OP_NOP write nothing.
  localparam logic [3:0] OP_NOP  = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_seq_comb.sv
// rtl/alu_seq_comb.sv - combinational single-cycle op unit (everything except MUL)
module alu_seq_comb
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic [3:0]       opcode,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  localparam logic [WIDTH-1:0] W_L = WIDTH[WIDTH-1:0];

  logic [WIDTH-1:0] amt;

  always_comb begin
    amt    = b % W_L;
    result = '0;
    carry  = 1'b0;
    case (opcode)
      OP_ADD:  {carry, result} = {1'b0, a} + {1'b0, b};
      OP_SUB:  {carry, result} = {1'b0, a} - {1'b0, b};
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      // The extra bit on either side catches the last bit shifted out.
      OP_SHL:  {carry, result} = {1'b0, a} << amt;
      OP_SHR:  {result, carry} = {a, 1'b0} >> amt;
      OP_LOAD: result = b;
      OP_ADC:  {carry, result} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq_core.sv
// rtl/alu_seq_core.sv - register-file ALU with valid/ready issue and a shift-add multiplier
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREGS = 4,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [AW-1:0]    rd_addr,
  input  logic [AW-1:0]    rs_addr,
  input  logic [AW-1:0]    rt_addr,
  input  logic             use_imm,
  input  logic [WIDTH-1:0] imm,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             neg_flag
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0]   regs [NREGS];
  state_t             state;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic [AW-1:0]      mul_rd;

  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic [2*WIDTH-1:0] acc_next;

  assign op_a     = regs[rs_addr];
  assign op_b     = use_imm ? imm : regs[rt_addr];
  assign in_ready = ena & (state == ST_IDLE);
  assign acc_next = acc + (mplier[0] ? mcand : '0);

  alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
    .a        (op_a),
    .b        (op_b),
    .carry_in (carry_flag),
    .opcode   (opcode),
    .result   (alu_res),
    .carry    (alu_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      state      <= ST_IDLE;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
      mul_rd     <= '0;
      out_valid  <= 1'b0;
      result     <= '0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
      neg_flag   <= 1'b0;
    end else if (ena) begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (opcode == OP_MUL) begin
              mcand  <= {{WIDTH{1'b0}}, op_a};
              mplier <= op_b;
              acc    <= '0;
              cnt    <= '0;
              mul_rd <= rd_addr;
              state  <= ST_MUL;
            end else begin
              out_valid <= 1'b1;
              if (opcode < OP_NOP) begin
                regs[rd_addr] <= alu_res;
                result        <= alu_res;
                zero_flag     <= (alu_res == '0);
                carry_flag    <= alu_carry;
                neg_flag      <= alu_res[WIDTH-1];
              end
            end
          end
        end
        ST_MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // Last iteration retires straight from acc_next, no extra cycle.
          if (cnt == LAST) begin
            regs[mul_rd] <= acc_next[WIDTH-1:0];
            result       <= acc_next[WIDTH-1:0];
            zero_flag    <= (acc_next[WIDTH-1:0] == '0);
            carry_flag   <= |acc_next[2*WIDTH-1:WIDTH];
            neg_flag     <= acc_next[WIDTH-1];
            out_valid    <= 1'b1;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
